// File: rtl/div_unit_pkg.sv
// Shared pipeline encodings for the iterative divider: div_op values and FSM state codes.
package div_unit_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic is_rem_op(input logic [1:0] op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow are resolved at accept and skip the iteration phase.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  flush,
    input  logic [1:0]            div_op,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [1:0]            op_q, op_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    // Operand conditioning at accept
    logic                  in_signed, a_neg, b_neg, div_zero, sgn_ovf;
    logic [DATA_WIDTH-1:0] a_mag, b_mag, special_res;

    assign in_signed = is_signed_op(div_op);
    assign a_neg     = in_signed & in1[DATA_WIDTH-1];
    assign b_neg     = in_signed & in2[DATA_WIDTH-1];
    assign a_mag     = a_neg ? -in1 : in1;
    assign b_mag     = b_neg ? -in2 : in2;
    assign div_zero  = (in2 == '0);
    assign sgn_ovf   = in_signed && (in1 == MinNeg) && (in2 == '1);

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = is_rem_op(div_op) ? in1 : '1;
        end else begin
            special_res = is_rem_op(div_op) ? '0 : MinNeg;
        end
    end

    // One restoring step; rem_q < divisor_q holds, so the shifted value fits after subtraction
    logic [DATA_WIDTH:0]   rem_sh, diff;
    logic [DATA_WIDTH-1:0] step_rem, step_quo, fix_rem, fix_quo;

    assign rem_sh   = {rem_q, quo_q[DATA_WIDTH-1]};
    assign diff     = rem_sh - {1'b0, divisor_q};
    assign step_rem = diff[DATA_WIDTH] ? rem_sh[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
    assign step_quo = {quo_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
    assign fix_quo  = neg_quo_q ? -step_quo : step_quo;
    assign fix_rem  = neg_rem_q ? -step_rem : step_rem;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        divisor_d = divisor_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        result_d  = result_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_d      = div_op;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        divisor_d = b_mag;
                        quo_d     = a_mag;
                        rem_d     = '0;
                        cnt_d     = '0;
                        if (div_zero || sgn_ovf) begin
                            result_d = special_res;
                            state_d  = S_DONE;
                        end else begin
                            state_d  = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    quo_d = step_quo;
                    rem_d = step_rem;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        result_d = is_rem_op(op_q) ? fix_rem : fix_quo;
                        state_d  = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divisor_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            divisor_q <= divisor_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
        end
    end

    assign ready  = (state_q == S_IDLE);
    assign busy   = (state_q == S_CALC) || (state_q == S_DONE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: arithmetic, special cases, latency, flush and reset.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [1:0]  div_op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_vec = 0;
    int n_err = 0;

    div_unit #(.DATA_WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flush  (flush),
        .div_op (div_op),
        .in1    (in1),
        .in2    (in2),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Waits for ready, issues one request, returns result and cycles from accept to done (-1 on timeout)
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        div_op = op; in1 = a; in2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        res = result;
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; div_op = 2'b00; in1 = '0; in2 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
        n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h exp 0", result); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        logic [1:0]  op_t  [5] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b01};
        logic [31:0] a_t   [5] = '{32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] b_t   [5] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd2};
        logic [31:0] exp_t [5] = '{32'h0000000E, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                   32'h7FFFFFFC};
        logic [31:0] res;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            do_op(op_t[i], a_t[i], b_t[i], res, lat);
            n_vec++;
            if (res !== exp_t[i]) begin
                n_err++; $display("FAIL arith_%0d result got %h exp %h", i, res, exp_t[i]);
            end
            n_vec++;
            if (lat != 33) begin
                n_err++; $display("FAIL arith_%0d latency got %0d exp 33", i, lat);
            end
        end
    endtask

    task automatic test_special();
        logic [1:0]  op_t  [5] = '{2'b01, 2'b11, 2'b00, 2'b00, 2'b10};
        logic [31:0] a_t   [5] = '{32'h1234, 32'h1234, 32'hFFFFFFFB, 32'h80000000, 32'h80000000};
        logic [31:0] b_t   [5] = '{32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp_t [5] = '{32'hFFFFFFFF, 32'h00001234, 32'hFFFFFFFF, 32'h80000000,
                                   32'h00000000};
        logic [31:0] res;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            do_op(op_t[i], a_t[i], b_t[i], res, lat);
            n_vec++;
            if (res !== exp_t[i]) begin
                n_err++; $display("FAIL special_%0d result got %h exp %h", i, res, exp_t[i]);
            end
            n_vec++;
            if (lat != 1) begin
                n_err++; $display("FAIL special_%0d latency got %0d exp 1", i, lat);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        while (ready !== 1'b1) begin @(posedge clk); #1; end
        div_op = 2'b00; in1 = 32'd100; in2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        div_op = 2'b01; in1 = 32'd50; in2 = 32'd5;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        start = 1'b0;
        n_vec++;
        if (result !== 32'h0000000E) begin
            n_err++; $display("FAIL busy_start result got %h exp 0000000e", result);
        end
        n_vec++;
        if (lat != 33) begin n_err++; $display("FAIL busy_start latency got %0d exp 33", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        logic seen;
        while (ready !== 1'b1) begin @(posedge clk); #1; end
        div_op = 2'b01; in1 = 32'd1000; in2 = 32'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        repeat (9) begin @(posedge clk); #1; seen |= done; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %b exp 1", ready); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL flush_done got %b exp 0", done); end
        n_vec++;
        if (result !== 32'h0000000E) begin
            n_err++; $display("FAIL flush_result got %h exp 0000000e", result);
        end
        repeat (40) begin @(posedge clk); #1; seen |= done; end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_no_done got %b exp 0", seen); end
    endtask

    task automatic test_flush_idle();
        div_op = 2'b00; in1 = 32'd100; in2 = 32'd7; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL flush_idle_ready got %b exp 1", ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        while (ready !== 1'b1) begin @(posedge clk); #1; end
        div_op = 2'b00; in1 = 32'd100; in2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready got %b exp 1", ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_mid_done got %b exp 0", done); end
        n_vec++;
        if (result !== 32'h0) begin n_err++; $display("FAIL rst_mid_result got %h exp 0", result); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int          lat;
        do_op(2'b01, 32'd10, 32'd3, res, lat);
        n_vec++; if (res !== 32'd3) begin n_err++; $display("FAIL b2b_0 result got %h exp 3", res); end
        n_vec++; if (lat != 33) begin n_err++; $display("FAIL b2b_0 latency got %0d exp 33", lat); end
        do_op(2'b01, 32'd9, 32'd3, res, lat);
        n_vec++; if (res !== 32'd3) begin n_err++; $display("FAIL b2b_1 result got %h exp 3", res); end
        n_vec++; if (lat != 33) begin n_err++; $display("FAIL b2b_1 latency got %0d exp 33", lat); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_special();
        test_start_while_busy();
        test_flush();
        test_flush_idle();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
